ram_stream_reader: RTL

Read-side sequencer placed directly downstream of the 1-read/1-write block RAM. On a `start` command it sweeps a run of consecutive RAM addresses and emits the words on a valid/ready stream, accounting for the RAM's one-cycle registered read latency. Backpressure is absorbed without losing or duplicating words. Consumers include UART/DMA-style senders that drain a buffer the write port has filled.

---
 rtl/ram_stream_reader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ram_stream_reader.sv
// Sweeps a run of block-RAM addresses and streams the words out on valid/ready.
// A 2-entry skid buffer plus an issue credit rule hides the RAM's 1-cycle read latency.
module ram_stream_reader #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_WIDTH-1:0] base_addr,
    input  logic [A_WIDTH:0]   length,
    output logic               busy,
    output logic               done,
    output logic [A_WIDTH-1:0] ram_address_read,
    input  logic [D_WIDTH-1:0] ram_data_read,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_last
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [A_WIDTH:0]   issue_q, issue_d;
    logic [A_WIDTH:0]   beat_q, beat_d;
    logic               inflight_q, inflight_d;
    logic               done_q, done_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [D_WIDTH-1:0] buf_q [2];
    logic               pop;
    logic               issue;

    assign out_valid        = (cnt_q != 2'd0);
    assign pop              = out_valid & out_ready;
    assign out_data         = out_valid ? buf_q[rd_q] : '0;
    assign out_last         = out_valid && (beat_q == 1);
    assign busy             = (state_q == RUN);
    assign done             = done_q;
    assign ram_address_read = addr_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        issue_d    = issue_q;
        beat_d     = beat_q;
        inflight_d = 1'b0;
        done_d     = 1'b0;
        issue      = 1'b0;
        cnt_d      = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        wr_d       = wr_q ^ inflight_q;
        rd_d       = rd_q ^ pop;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d = RUN;
                        addr_d  = base_addr;
                        issue_d = length;
                        beat_d  = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Only issue when the word can land without overflowing the buffer.
                issue = (issue_q != '0) &&
                        (({1'b0, cnt_q} + {2'b0, inflight_q}) <= (3'd1 + {2'b0, pop}));
                if (issue) begin
                    addr_d     = addr_q + 1'b1;
                    issue_d    = issue_q - 1'b1;
                    inflight_d = 1'b1;
                end
                if (pop) begin
                    beat_d = beat_q - 1'b1;
                    if (beat_q == 1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            issue_q    <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= 2'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            issue_q    <= issue_d;
            beat_q     <= beat_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (inflight_q && !rst) begin
            buf_q[wr_q] <= ram_data_read;
        end
    end

endmodule
